serial_operand_feeder: RTL

//   Upstream stage of the bit-serial unsigned comparator. Captures two WIDTH-bit

---
 rtl/serial_operand_feeder.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_operand_feeder.sv
// Captures two unsigned operands on start and streams them out one bit-pair per
// cycle under a valid/ready handshake, framing the stream with first/last flags.
module serial_operand_feeder #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_first,
    output logic             bit_last,
    output logic             done
);
    localparam int CW      = $clog2(WIDTH);
    localparam int OUT_POS = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             last_pos;
    logic             xfer;

    assign last_pos = (cnt == CW'(WIDTH - 1));
    assign xfer     = (state == SHIFT) && bit_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (xfer && last_pos) state_nxt = DONE_ST;
            DONE_ST: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        bit_valid = 1'b0;
        bit_first = 1'b0;
        bit_last  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            SHIFT: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                bit_first = (cnt == '0);
                bit_last  = last_pos;
            end
            DONE_ST: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    // The output end of each register is fixed; shifting moves the next bit into it.
    assign a_bit = sh_a[OUT_POS];
    assign b_bit = sh_b[OUT_POS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_a <= '0;
            sh_b <= '0;
            cnt  <= '0;
        end else if ((state == IDLE) && start) begin
            sh_a <= a_in;
            sh_b <= b_in;
            cnt  <= '0;
        end else if (xfer) begin
            if (MSB_FIRST) begin
                sh_a <= {sh_a[WIDTH-2:0], 1'b0};
                sh_b <= {sh_b[WIDTH-2:0], 1'b0};
            end else begin
                sh_a <= {1'b0, sh_a[WIDTH-1:1]};
                sh_b <= {1'b0, sh_b[WIDTH-1:1]};
            end
            // Hold at the last position so the counter never wraps.
            if (!last_pos) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
